// File: rtl/sensor_debounce_scheduler.sv
// Multi-channel debouncer: one shared engine scans channels round-robin and
// queues one pending event per channel, presented over a valid/ack handshake.
module sensor_debounce_scheduler #(
  parameter int CHANNELS     = 4,
  parameter int STABLE_SCANS = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] noisy,
  input  logic                enable,
  output logic [CHANNELS-1:0] debounced,
  output logic                event_valid,
  output logic [2:0]          event_channel,
  output logic                event_level,
  input  logic                event_ack,
  output logic [CHANNELS-1:0] overrun
);

  localparam int              IW       = (CHANNELS <= 2) ? 1 : $clog2(CHANNELS);
  localparam logic [0:0]      S_IDLE    = 1'b0;
  localparam logic [0:0]      S_PRESENT = 1'b1;
  localparam logic [7:0]      CNT_LAST  = 8'(STABLE_SCANS - 1);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(CHANNELS - 1);
  localparam logic [IW:0]     CH_W      = (IW + 1)'(CHANNELS);

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [IW-1:0]       r_scan_idx;
  logic [7:0]          r_cnt [CHANNELS];
  logic [CHANNELS-1:0] r_deb;
  logic [CHANNELS-1:0] r_pending;
  logic [CHANNELS-1:0] r_pend_level;
  logic [CHANNELS-1:0] r_overrun;
  logic [0:0]          r_state;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_ev_ch;
  logic                r_ev_lvl;
  logic                r_ev_vld;

  logic                w_grant_vld;
  logic [IW-1:0]       w_grant_ch;
  logic [IW:0]         w_sum;
  logic                w_grant_fire;
  logic [CHANNELS-1:0] w_grant_oh;
  logic [CHANNELS-1:0] w_accept;

  // Reverse walk so the nearest pending channel at or above rr_ptr wins.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_ch  = '0;
    w_sum       = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_rr_ptr} + (IW + 1)'(i);
      if (w_sum >= CH_W) w_sum = w_sum - CH_W;
      if (r_pending[w_sum[IW-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_ch  = w_sum[IW-1:0];
      end
    end
  end

  assign w_grant_fire = (r_state == S_IDLE) && w_grant_vld;

  always_comb begin
    w_grant_oh = '0;
    w_accept   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_grant_oh[c] = w_grant_fire && (w_grant_ch == IW'(c));
      w_accept[c]   = enable && (r_scan_idx == IW'(c)) &&
                      (r_sync2[c] != r_deb[c]) && (r_cnt[c] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_scan_idx   <= '0;
      r_deb        <= '0;
      r_pending    <= '0;
      r_pend_level <= '0;
      r_overrun    <= '0;
      for (int c = 0; c < CHANNELS; c++) r_cnt[c] <= '0;
    end else begin
      r_sync1 <= noisy;
      r_sync2 <= r_sync1;
      if (enable) r_scan_idx <= (r_scan_idx == IDX_LAST) ? '0 : r_scan_idx + IW'(1);
      for (int c = 0; c < CHANNELS; c++) begin
        if (enable && (r_scan_idx == IW'(c))) begin
          if (r_sync2[c] == r_deb[c]) begin
            r_cnt[c] <= '0;
          end else if (r_cnt[c] == CNT_LAST) begin
            r_deb[c] <= r_sync2[c];
            r_cnt[c] <= '0;
          end else begin
            r_cnt[c] <= r_cnt[c] + 8'd1;
          end
        end
        // A fresh acceptance beats a same-cycle grant; the grant carries the old level.
        if (w_accept[c]) begin
          r_pending[c]    <= 1'b1;
          r_pend_level[c] <= r_sync2[c];
          if (r_pending[c] && !w_grant_oh[c]) r_overrun[c] <= 1'b1;
        end else if (w_grant_oh[c]) begin
          r_pending[c] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_ev_ch  <= '0;
      r_ev_lvl <= 1'b0;
      r_ev_vld <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_ev_ch  <= w_grant_ch;
            r_ev_lvl <= r_pend_level[w_grant_ch];
            r_ev_vld <= 1'b1;
            r_state  <= S_PRESENT;
          end
        end
        default: begin
          if (event_ack) begin
            r_ev_vld <= 1'b0;
            r_rr_ptr <= (r_ev_ch == IDX_LAST) ? '0 : r_ev_ch + IW'(1);
            r_state  <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign debounced     = r_deb;
  assign overrun       = r_overrun;
  assign event_valid   = r_ev_vld;
  assign event_channel = 3'(r_ev_ch);
  assign event_level   = r_ev_lvl;

endmodule

// File: tb/tb_sensor_debounce_scheduler.sv
// Directed bench for sensor_debounce_scheduler with CHANNELS=4, STABLE_SCANS=3.
module tb_sensor_debounce_scheduler;

  logic       clk;
  logic       reset;
  logic [3:0] noisy;
  logic       enable;
  logic [3:0] debounced;
  logic       event_valid;
  logic [2:0] event_channel;
  logic       event_level;
  logic       event_ack;
  logic [3:0] overrun;

  logic       ack_auto;
  logic       ack_man;
  int         checks;
  int         errors;
  logic [3:0] ev_q [$];

  sensor_debounce_scheduler #(.CHANNELS(4), .STABLE_SCANS(3)) dut (
    .clk(clk), .reset(reset), .noisy(noisy), .enable(enable),
    .debounced(debounced), .event_valid(event_valid),
    .event_channel(event_channel), .event_level(event_level),
    .event_ack(event_ack), .overrun(overrun)
  );

  assign event_ack = ack_auto ? event_valid : ack_man;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each handshake as {channel, level}.
  always @(negedge clk) begin
    if (reset && event_valid && event_ack) ev_q.push_back({event_channel, event_level});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] nz);
    reset    = 1'b0;
    noisy    = nz;
    enable   = 1'b1;
    ack_auto = 1'b0;
    ack_man  = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    ev_q.delete();
  endtask

  task automatic test_reset();
    logic [3:0] m;
    m = 4'b0000;
    reset = 1'b0; noisy = 4'b1111; enable = 1'b1; ack_auto = 1'b0; ack_man = 1'b0;
    repeat (3) tick();
    checks++; if (debounced !== 4'b0000) begin errors++; $display("FAIL reset_debounced got %b want 0000", debounced); end
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", event_valid); end
    checks++; if (event_channel !== 3'd0) begin errors++; $display("FAIL reset_channel got %0d want 0", event_channel); end
    checks++; if (event_level !== 1'b0) begin errors++; $display("FAIL reset_level got %b want 0", event_level); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL reset_overrun got %b want 0000", overrun); end
    reset = 1'b1; ack_auto = 1'b1; ev_q.delete();
    // Channels accept at edges 11,12,13,14 (ch2,ch3,ch0,ch1) after release.
    repeat (13) tick();
    checks++; if (debounced !== 4'b1101) begin errors++; $display("FAIL reset_deb13 got %b want 1101", debounced); end
    tick();
    checks++; if (debounced !== 4'b1111) begin errors++; $display("FAIL reset_deb14 got %b want 1111", debounced); end
    repeat (20) tick();
    checks++; if (ev_q.size() != 4) begin errors++; $display("FAIL reset_evcount got %0d want 4", ev_q.size()); end
    foreach (ev_q[i]) begin
      m[ev_q[i][2:1]] = 1'b1;
      checks++; if (ev_q[i][0] !== 1'b1) begin errors++; $display("FAIL reset_evlevel idx %0d got %b want 1", i, ev_q[i][0]); end
    end
    checks++; if (m !== 4'b1111) begin errors++; $display("FAIL reset_evchannels got %b want 1111", m); end
  endtask

  task automatic test_single_change();
    int lat;
    int vcnt;
    lat = 0; vcnt = 0;
    do_reset(4'b0000);
    ack_auto = 1'b1;
    noisy = 4'b0010;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (debounced[1] && lat == 0) lat = k;
      if (event_valid) vcnt++;
    end
    checks++; if (lat != 14) begin errors++; $display("FAIL single_latency got %0d want 14", lat); end
    checks++; if (debounced !== 4'b0010) begin errors++; $display("FAIL single_debounced got %b want 0010", debounced); end
    checks++; if (vcnt != 1) begin errors++; $display("FAIL single_valid_cycles got %0d want 1", vcnt); end
    checks++;
    if (ev_q.size() != 1 || ev_q[0] !== 4'b0011) begin
      errors++; $display("FAIL single_event got count %0d first %b want count 1 first 0011", ev_q.size(), ev_q.size() > 0 ? ev_q[0] : 4'hx);
    end
  endtask

  task automatic test_glitch();
    int vcnt;
    vcnt = 0;
    do_reset(4'b0000);
    ack_auto = 1'b1;
    noisy = 4'b0100;
    repeat (6) tick();
    noisy = 4'b0000;
    repeat (2) tick();
    checks++; if (dut.r_cnt[2] !== 8'd2) begin errors++; $display("FAIL glitch_cnt_mid got %0d want 2", dut.r_cnt[2]); end
    for (int k = 0; k < 30; k++) begin
      tick();
      if (event_valid) vcnt++;
    end
    checks++; if (debounced !== 4'b0000) begin errors++; $display("FAIL glitch_debounced got %b want 0000", debounced); end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL glitch_valid_cycles got %0d want 0", vcnt); end
    checks++; if (dut.r_cnt[2] !== 8'd0) begin errors++; $display("FAIL glitch_cnt_end got %0d want 0", dut.r_cnt[2]); end
  endtask

  task automatic test_slow_consumer();
    int k;
    do_reset(4'b0000);
    // Align so ch0's first synchronized visit precedes ch3's.
    repeat (2) tick();
    noisy = 4'b1001;
    k = 0;
    while (!event_valid && k < 40) begin tick(); k++; end
    checks++; if (k != 12) begin errors++; $display("FAIL slow_first_wait got %0d want 12", k); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (event_valid !== 1'b1 || event_channel !== 3'd0 || event_level !== 1'b1) begin
        errors++; $display("FAIL slow_hold0 cyc %0d got v%b ch%0d l%b want v1 ch0 l1", i, event_valid, event_channel, event_level);
      end
      tick();
    end
    ack_man = 1'b1; tick(); ack_man = 1'b0;
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL slow_idle_gap got %b want 0", event_valid); end
    tick();
    checks++;
    if (event_valid !== 1'b1 || event_channel !== 3'd3 || event_level !== 1'b1) begin
      errors++; $display("FAIL slow_second got v%b ch%0d l%b want v1 ch3 l1", event_valid, event_channel, event_level);
    end
    repeat (4) tick();
    ack_man = 1'b1; tick(); ack_man = 1'b0;
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL slow_after_ack got %b want 0", event_valid); end
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL slow_overrun got %b want 0000", overrun); end
    checks++;
    if (ev_q.size() != 2 || ev_q[0] !== 4'b0001 || ev_q[1] !== 4'b0111) begin
      errors++; $display("FAIL slow_order got count %0d want count 2 seq 0001,0111", ev_q.size());
    end
  endtask

  task automatic test_overrun();
    do_reset(4'b0000);
    noisy = 4'b0010;
    repeat (20) tick();
    noisy = 4'b0000;
    repeat (19) tick();
    checks++; if (overrun !== 4'b0000) begin errors++; $display("FAIL ovr_before got %b want 0000", overrun); end
    checks++;
    if (event_valid !== 1'b1 || event_channel !== 3'd1 || event_level !== 1'b1) begin
      errors++; $display("FAIL ovr_presented got v%b ch%0d l%b want v1 ch1 l1", event_valid, event_channel, event_level);
    end
    tick();
    noisy = 4'b0010;
    repeat (20) tick();
    checks++; if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_flag got %b want 0010", overrun); end
    ack_auto = 1'b1;
    repeat (10) tick();
    checks++;
    if (ev_q.size() != 2 || ev_q[0] !== 4'b0011 || ev_q[1] !== 4'b0011) begin
      errors++; $display("FAIL ovr_events got count %0d want count 2 seq 0011,0011", ev_q.size());
    end
    checks++; if (overrun !== 4'b0010) begin errors++; $display("FAIL ovr_sticky got %b want 0010", overrun); end
  endtask

  task automatic test_freeze_abort();
    do_reset(4'b0000);
    noisy = 4'b0010;
    repeat (10) tick();
    enable = 1'b0;
    checks++; if (dut.r_cnt[1] !== 8'd2) begin errors++; $display("FAIL freeze_cnt_start got %0d want 2", dut.r_cnt[1]); end
    repeat (8) tick();
    checks++; if (dut.r_cnt[1] !== 8'd2) begin errors++; $display("FAIL freeze_cnt_hold got %0d want 2", dut.r_cnt[1]); end
    checks++; if (dut.r_scan_idx !== 2'd2) begin errors++; $display("FAIL freeze_scan_hold got %0d want 2", dut.r_scan_idx); end
    checks++; if (debounced !== 4'b0000) begin errors++; $display("FAIL freeze_deb_hold got %b want 0000", debounced); end
    enable = 1'b1;
    repeat (3) tick();
    checks++; if (debounced !== 4'b0000) begin errors++; $display("FAIL resume_deb3 got %b want 0000", debounced); end
    tick();
    checks++; if (debounced !== 4'b0010) begin errors++; $display("FAIL resume_deb4 got %b want 0010", debounced); end
    tick();
    checks++;
    if (event_valid !== 1'b1 || event_channel !== 3'd1 || event_level !== 1'b1) begin
      errors++; $display("FAIL resume_event got v%b ch%0d l%b want v1 ch1 l1", event_valid, event_channel, event_level);
    end
    reset = 1'b0;
    tick();
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", event_valid); end
    checks++; if (dut.r_pending !== 4'b0000) begin errors++; $display("FAIL abort_pending got %b want 0000", dut.r_pending); end
    checks++; if (debounced !== 4'b0000) begin errors++; $display("FAIL abort_debounced got %b want 0000", debounced); end
    reset = 1'b1;
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b0; noisy = 4'b0000; enable = 1'b1; ack_auto = 1'b0; ack_man = 1'b0;
    test_reset();
    test_single_change();
    test_glitch();
    test_slow_consumer();
    test_overrun();
    test_freeze_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
